// File: rtl/ic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ic_pkg
// Description : Shared definitions for the 16-bit {addr[3:0],data[11:0]}
//               control link: frame addresses, control-word field
//               positions, control-word layout and a frame builder.
// Revision    : 1.0 - initial release
// ============================================================================
package ic_pkg;

  // Frame address of each control-word field (address 1 is the heartbeat)
  typedef enum logic [3:0] {
    ADDR_HB     = 4'd1,
    ADDR_ANGLE  = 4'd2,
    ADDR_PERIOD = 4'd3,
    ADDR_MODE   = 4'd4,
    ADDR_CMD    = 4'd5,
    ADDR_POWER  = 4'd6
  } ic_addr_e;

  // Field bit positions inside the 32-bit control word
  localparam int c_ANGLE_LSB  = 0;
  localparam int c_ANGLE_MSB  = 11;
  localparam int c_PERIOD_LSB = 12;
  localparam int c_PERIOD_MSB = 19;
  localparam int c_MODE_LSB   = 27;
  localparam int c_MODE_MSB   = 28;
  localparam int c_CMD_LSB    = 29;
  localparam int c_CMD_MSB    = 30;
  localparam int c_POWER_BIT  = 31;

  // Pending-flag index of each field; index order equals address order
  localparam int c_NUM_FIELDS = 5;
  localparam int c_IDX_ANGLE  = 0;
  localparam int c_IDX_PERIOD = 1;
  localparam int c_IDX_MODE   = 2;
  localparam int c_IDX_CMD    = 3;
  localparam int c_IDX_POWER  = 4;

  localparam int c_FRAME_W    = 16;

  typedef struct packed {
    logic        power;
    logic [1:0]  cmd;
    logic [1:0]  mode;
    logic [6:0]  rsvd;
    logic [7:0]  period;
    logic [11:0] angle;
  } ctrl_word_t;

  // Build a link frame from an address and an LSB-aligned data field
  function automatic logic [c_FRAME_W-1:0] make_frame(input ic_addr_e addr,
                                                      input logic [11:0] data);
    return {addr, data};
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_shift_tx.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_tx
// Description : SPI mode-0 master shifter for one 16-bit frame, MSB first.
//               Sequence SETUP -> SHIFT -> HOLD -> GAP, each phase timed in
//               units of CLK_DIV clock cycles. A new frame may be accepted
//               on the last GAP cycle so frames run back to back.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_shift_tx
  import ic_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 load,
  input  logic [c_FRAME_W-1:0] frame,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 cs_n,
  output logic                 busy,
  output logic                 done,
  output logic                 ready
);

  localparam int                 c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_SETUP = 3'd1;
  localparam logic [2:0] c_SHIFT = 3'd2;
  localparam logic [2:0] c_HOLD  = 3'd3;
  localparam logic [2:0] c_GAP   = 3'd4;

  logic [2:0]           r_state;
  logic [2:0]           w_nextState;
  logic [c_DIV_W-1:0]   r_div;
  logic [3:0]           r_bitCnt;
  logic                 r_sclkHigh;
  logic [c_FRAME_W-1:0] r_shift;

  logic w_divEnd;
  logic w_lastBit;
  logic w_accept;

  assign w_divEnd  = (r_div == c_DIV_LAST);
  assign w_lastBit = (r_bitCnt == 4'd15);
  assign w_accept  = load && ready;

  // State register; reset drops the link immediately
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state: each phase ends when the divider wraps
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE: begin
        if (load) w_nextState = c_SETUP;
      end
      c_SETUP: begin
        if (w_divEnd) w_nextState = c_SHIFT;
      end
      c_SHIFT: begin
        if (w_divEnd && r_sclkHigh && w_lastBit) w_nextState = c_HOLD;
      end
      c_HOLD: begin
        if (w_divEnd) w_nextState = c_GAP;
      end
      c_GAP: begin
        if (w_divEnd) w_nextState = load ? c_SETUP : c_IDLE;
      end
      default: w_nextState = c_IDLE;
    endcase
  end

  // Outputs decoded from state; mosi is the head of the shift register
  always_comb begin
    sclk  = 1'b0;
    mosi  = 1'b0;
    cs_n  = 1'b1;
    busy  = 1'b1;
    done  = 1'b0;
    ready = 1'b0;
    case (r_state)
      c_IDLE: begin
        busy  = 1'b0;
        ready = 1'b1;
      end
      c_SETUP: begin
        cs_n = 1'b0;
        mosi = r_shift[c_FRAME_W-1];
      end
      c_SHIFT: begin
        cs_n = 1'b0;
        mosi = r_shift[c_FRAME_W-1];
        sclk = r_sclkHigh;
      end
      c_HOLD: begin
        cs_n = 1'b0;
        mosi = r_shift[c_FRAME_W-1];
      end
      c_GAP: begin
        done  = w_divEnd;
        ready = w_divEnd;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Divider, bit counter and shift register; shift happens as sclk falls
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_div      <= '0;
      r_bitCnt   <= '0;
      r_sclkHigh <= 1'b0;
      r_shift    <= '0;
    end else if (w_accept) begin
      r_shift    <= frame;
      r_div      <= '0;
      r_bitCnt   <= '0;
      r_sclkHigh <= 1'b0;
    end else if (r_state != c_IDLE) begin
      r_div <= w_divEnd ? '0 : r_div + 1'b1;
      if ((r_state == c_SHIFT) && w_divEnd) begin
        if (r_sclkHigh) begin
          r_sclkHigh <= 1'b0;
          r_bitCnt   <= w_lastBit ? 4'd0 : r_bitCnt + 4'd1;
          r_shift    <= {r_shift[c_FRAME_W-2:0], 1'b0};
        end else begin
          r_sclkHigh <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_tx
// Description : Transmit end of the control link. Watches the 32-bit control
//               word and sends one {addr,data} frame per changed field,
//               lowest address first, through spi_shift_tx.
//               Optional heartbeat frame {4'd1,12'h000} after HB_CYCLES idle
//               cycles, enabled by defining SPI_TX_HEARTBEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_tx
  import ic_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int HB_CYCLES = 50000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] ctrl_word,
  input  logic        resend_all,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  output logic        busy,
  output logic        frame_done
);

  ctrl_word_t                r_shadow;
  ctrl_word_t                w_cur;
  logic [c_NUM_FIELDS-1:0]   r_pending;
  logic [c_NUM_FIELDS-1:0]   w_diff;
  logic [c_NUM_FIELDS-1:0]   w_sel;
  logic [c_NUM_FIELDS-1:0]   w_clear;
  logic [c_FRAME_W-1:0]      w_frame;
  logic                      w_anyPending;
  logic                      w_hbReq;
  logic                      w_ready;
  logic                      w_busy;
  logic                      w_load;

  // Field view of the live control word; reserved bits are not tracked
  always_comb begin
    w_cur        = '0;
    w_cur.angle  = ctrl_word[c_ANGLE_MSB:c_ANGLE_LSB];
    w_cur.period = ctrl_word[c_PERIOD_MSB:c_PERIOD_LSB];
    w_cur.mode   = ctrl_word[c_MODE_MSB:c_MODE_LSB];
    w_cur.cmd    = ctrl_word[c_CMD_MSB:c_CMD_LSB];
    w_cur.power  = ctrl_word[c_POWER_BIT];
  end

  // Change detect against the value last sent for each field
  always_comb begin
    w_diff               = '0;
    w_diff[c_IDX_ANGLE]  = (w_cur.angle  != r_shadow.angle);
    w_diff[c_IDX_PERIOD] = (w_cur.period != r_shadow.period);
    w_diff[c_IDX_MODE]   = (w_cur.mode   != r_shadow.mode);
    w_diff[c_IDX_CMD]    = (w_cur.cmd    != r_shadow.cmd);
    w_diff[c_IDX_POWER]  = (w_cur.power  != r_shadow.power);
  end

  assign w_anyPending = |r_pending;

  // Priority encoder: lowest pending address wins, heartbeat frame otherwise
  always_comb begin
    w_sel   = '0;
    w_frame = make_frame(ADDR_HB, 12'h000);
    if (r_pending[c_IDX_ANGLE]) begin
      w_sel[c_IDX_ANGLE] = 1'b1;
      w_frame = make_frame(ADDR_ANGLE, w_cur.angle);
    end else if (r_pending[c_IDX_PERIOD]) begin
      w_sel[c_IDX_PERIOD] = 1'b1;
      w_frame = make_frame(ADDR_PERIOD, {4'h0, w_cur.period});
    end else if (r_pending[c_IDX_MODE]) begin
      w_sel[c_IDX_MODE] = 1'b1;
      w_frame = make_frame(ADDR_MODE, {10'h000, w_cur.mode});
    end else if (r_pending[c_IDX_CMD]) begin
      w_sel[c_IDX_CMD] = 1'b1;
      w_frame = make_frame(ADDR_CMD, {10'h000, w_cur.cmd});
    end else if (r_pending[c_IDX_POWER]) begin
      w_sel[c_IDX_POWER] = 1'b1;
      w_frame = make_frame(ADDR_POWER, {11'h000, w_cur.power});
    end
  end

  assign w_load  = w_ready && (w_anyPending || w_hbReq);
  assign w_clear = w_load ? w_sel : '0;

  // Pending flags: the loaded field takes the live value, so its own change
  // is consumed; any other change or a resend request sets the flag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clear)
                 | (w_diff & ~w_clear)
                 | {c_NUM_FIELDS{resend_all}};
    end
  end

  // Shadow copy: record the value carried by the frame being loaded
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_shadow <= '0;
    end else begin
      if (w_clear[c_IDX_ANGLE])  r_shadow.angle  <= w_cur.angle;
      if (w_clear[c_IDX_PERIOD]) r_shadow.period <= w_cur.period;
      if (w_clear[c_IDX_MODE])   r_shadow.mode   <= w_cur.mode;
      if (w_clear[c_IDX_CMD])    r_shadow.cmd    <= w_cur.cmd;
      if (w_clear[c_IDX_POWER])  r_shadow.power  <= w_cur.power;
    end
  end

`ifdef SPI_TX_HEARTBEAT_EN
  localparam int c_HB_W = $clog2(HB_CYCLES + 1);

  logic [c_HB_W-1:0] r_idleCnt;

  assign w_hbReq = (r_idleCnt == c_HB_W'(HB_CYCLES));

  // Idle counter: runs only on a quiet link, restarts with every load
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_idleCnt <= '0;
    end else if (w_load) begin
      r_idleCnt <= '0;
    end else if (!w_busy && !w_anyPending && !w_hbReq) begin
      r_idleCnt <= r_idleCnt + 1'b1;
    end
  end
`else
  assign w_hbReq = 1'b0;
`endif

  spi_shift_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .CLK   (CLK),
    .RST_N (RST_N),
    .load  (w_load),
    .frame (w_frame),
    .sclk  (sclk),
    .mosi  (mosi),
    .cs_n  (cs_n),
    .busy  (w_busy),
    .done  (frame_done),
    .ready (w_ready)
  );

  assign busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_frame_tx
// Description : Directed bench for spi_frame_tx (CLK_DIV=2, HB_CYCLES=200).
//               A bus monitor rebuilds frames from sclk/mosi/cs_n; vector
//               table plus hand-written reset and heartbeat sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_frame_tx;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] ctrl_word;
  logic        resend_all;
  logic        sclk, mosi, cs_n, busy, frame_done;

  int nChecks = 0;
  int nPass   = 0;

  spi_frame_tx #(.CLK_DIV(2), .HB_CYCLES(200)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .ctrl_word  (ctrl_word),
    .resend_all (resend_all),
    .sclk       (sclk),
    .mosi       (mosi),
    .cs_n       (cs_n),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 CLK = ~CLK;

  // Captured frame as seen on the wire
  typedef struct {
    logic [15:0] data;
    int          nbits;
    int          low;
    int          gap;
  } frame_t;

  frame_t frames[$];
  int     doneQ[$];
  int     cyc       = 0;
  int     fallCyc   = 0;
  int     riseCyc   = 0;
  int     lastDone  = 0;

  // Bus monitor: sample on the falling CLK edge, shift mosi on sclk rise
  initial begin : monitor
    logic        inFrame;
    logic        prevSclk;
    logic [15:0] shreg;
    int          nb, low, gapRec;
    inFrame = 1'b0; prevSclk = 1'b0; shreg = '0; nb = 0; low = 0; gapRec = 0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (cs_n === 1'b0) begin
        if (!inFrame) begin
          inFrame = 1'b1; shreg = '0; nb = 0; low = 0;
          gapRec  = cyc - riseCyc;
          fallCyc = cyc;
        end
        low++;
        if (sclk && !prevSclk) begin
          shreg = {shreg[14:0], mosi};
          nb++;
        end
      end else if (inFrame) begin
        inFrame = 1'b0;
        frames.push_back('{shreg, nb, low, gapRec});
        riseCyc = cyc;
      end
      if (frame_done === 1'b1) begin
        doneQ.push_back(cyc - fallCyc);
        lastDone = cyc;
      end
      prevSclk = sclk;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Wait for 20 consecutive idle cycles, bounded
  task automatic wait_quiet();
    int q = 0;
    int t = 0;
    while (q < 20 && t < 4000) begin
      @(negedge CLK);
      t++;
      if (busy) q = 0; else q++;
    end
    if (q < 20) check("quiet_timeout", q, 20);
  endtask

  task automatic wait_cs_low();
    int t = 0;
    while (cs_n !== 1'b0 && t < 500) begin
      @(negedge CLK);
      t++;
    end
    if (cs_n !== 1'b0) check("cs_low_timeout", {31'd0, cs_n}, 0);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while (frames.size() < n && t < budget) begin
      @(negedge CLK);
      t++;
    end
    if (frames.size() < n) check("frame_timeout", frames.size(), n);
  endtask

  typedef struct {
    logic [31:0]          word;
    logic                 resend;
    int                   nexp;
    logic [0:4][15:0]     exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h0000_0343, 1'b0, 1, {16'h2343, 16'h0, 16'h0, 16'h0, 16'h0}};
    vecs[1] = '{32'h5804_3343, 1'b0, 3, {16'h3043, 16'h4003, 16'h5002, 16'h0, 16'h0}};
    vecs[2] = '{32'h5804_3343, 1'b0, 0, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0}};
    vecs[3] = '{32'hD804_3343, 1'b1, 5, {16'h2343, 16'h3043, 16'h4003, 16'h5002, 16'h6001}};
    vecs[4] = '{32'hD804_30AB, 1'b0, 1, {16'h20AB, 16'h0, 16'h0, 16'h0, 16'h0}};
    vecs[5] = '{32'hD814_30AB, 1'b0, 0, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0}};

    RST_N = 1'b0; ctrl_word = '0; resend_all = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_cs_n", {31'd0, cs_n}, 1);
    check("rst_sclk", {31'd0, sclk}, 0);
    check("rst_mosi", {31'd0, mosi}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, frame_done}, 0);
    RST_N = 1'b1;

    // Table-driven field changes
    for (int v = 0; v < 6; v++) begin
      frames.delete(); doneQ.delete();
      @(negedge CLK);
      ctrl_word  = vecs[v].word;
      resend_all = vecs[v].resend;
      @(negedge CLK);
      resend_all = 1'b0;
      wait_quiet();
      check($sformatf("v%0d_count", v), frames.size(), vecs[v].nexp);
      check($sformatf("v%0d_done_count", v), doneQ.size(), vecs[v].nexp);
      for (int k = 0; k < vecs[v].nexp; k++) begin
        if (k < frames.size()) begin
          check($sformatf("v%0d_f%0d_data", v, k), {16'd0, frames[k].data}, {16'd0, vecs[v].exp[k]});
          check($sformatf("v%0d_f%0d_bits", v, k), frames[k].nbits, 16);
          check($sformatf("v%0d_f%0d_cs_low", v, k), frames[k].low, 68);
          if (k > 0) check($sformatf("v%0d_f%0d_gap", v, k), frames[k].gap, 2);
        end
        if (k < doneQ.size()) check($sformatf("v%0d_f%0d_done_at", v, k), doneQ[k], 69);
      end
    end

    // Angle changes during its own frame: second frame carries new value
    frames.delete();
    ctrl_word = 32'hD804_3111;
    wait_cs_low();
    repeat (20) @(negedge CLK);
    ctrl_word = 32'hD804_3222;
    wait_quiet();
    check("rechange_count", frames.size(), 2);
    if (frames.size() > 0) check("rechange_f0", {16'd0, frames[0].data}, 32'h2111);
    if (frames.size() > 1) begin
      check("rechange_f1", {16'd0, frames[1].data}, 32'h2222);
      check("rechange_gap", frames[1].gap, 2);
    end

    // Reset in the middle of SHIFT: link drops in the same cycle
    ctrl_word = 32'hD804_3555;
    wait_cs_low();
    repeat (10) @(negedge CLK);
    check("pre_rst_cs_n", {31'd0, cs_n}, 0);
    RST_N = 1'b0;
    ctrl_word = '0;
    #1;
    check("midrst_cs_n", {31'd0, cs_n}, 1);
    check("midrst_sclk", {31'd0, sclk}, 0);
    check("midrst_mosi", {31'd0, mosi}, 0);
    check("midrst_busy", {31'd0, busy}, 0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    frames.delete(); doneQ.delete();
    repeat (150) @(negedge CLK);
    check("post_rst_frames", frames.size(), 0);
    check("post_rst_done", doneQ.size(), 0);

`ifdef SPI_TX_HEARTBEAT_EN
    // Heartbeat after idle, then a late field change takes priority
    wait_frames(1, 600);
    if (frames.size() > 0) check("hb_data", {16'd0, frames[0].data}, 32'h1000);
    repeat (190) @(negedge CLK);
    ctrl_word = 32'h0000_0777;
    wait_frames(3, 900);
    if (frames.size() > 1) check("hb_field_first", {16'd0, frames[1].data}, 32'h2777);
    if (frames.size() > 2) begin
      check("hb_after_field", {16'd0, frames[2].data}, 32'h1000);
      check("hb_restart", {31'd0, frames[2].gap >= 200}, 1);
    end
`else
    // Without the heartbeat a long idle link stays silent
    repeat (300) @(negedge CLK);
    check("no_hb_frames", frames.size(), 0);
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
